// File: rtl/any1_pkg.sv
// Shared ANY-1 fetch types: the aligner input record, line-slot record and fetch FSM states.
package any1_pkg;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned MAX_ILEN   = 16;
  localparam int unsigned AW         = 32;

  typedef struct packed {
    logic                                v;
    logic                                predict_taken;
    logic [(LINE_BYTES+MAX_ILEN)*8-1:0]  cacheline;
    logic [AW-1:0]                       ip;
    logic [AW-1:0]                       pip;
  } sInstAlignIn;

  typedef struct packed {
    logic [AW-1:0]           tag;
    logic                    v;
    logic [LINE_BYTES*8-1:0] data;
  } sFetchLine;

  typedef enum logic [1:0] {
    IFS_IDLE,
    IFS_FILL0,
    IFS_FILL1,
    IFS_RUN
  } eIfState;

endpackage

// File: rtl/any1_ifetch_lreg.sv
// One icache line slot of the fetch window: data, tag and valid, with load/invalidate and tag hit.
module any1_ifetch_lreg #(
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned AW         = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    inval,
  input  logic [AW-1:0]           load_tag,
  input  logic [LINE_BYTES*8-1:0] load_data,
  input  logic [AW-1:0]           cmp_tag,
  output logic                    v,
  output logic [AW-1:0]           tag,
  output logic [LINE_BYTES*8-1:0] data,
  output logic                    hit
);

  // A load in the same cycle as an invalidate wins: the fresh line is wanted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v    <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (load) begin
      v    <= 1'b1;
      tag  <= load_tag;
      data <= load_data;
    end else if (inval) begin
      v    <= 1'b0;
    end
  end

  assign hit = v && (tag == cmp_tag);

endmodule

// File: rtl/any1_ifetch_line.sv
// ANY-1 instruction line-fetch buffer: two-line window around the fetch IP feeding the aligner.
module any1_ifetch_line
  import any1_pkg::*;
#(
  parameter int unsigned    LINE_BYTES = 64,
  parameter int unsigned    MAX_ILEN   = 16,
  parameter int unsigned    AW         = 32,
  parameter logic [AW-1:0]  RST_ADDR   = 32'hFFFC0000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               ic_req_o,
  output logic [AW-1:0]                      ic_adr_o,
  input  logic                               ic_ack_i,
  input  logic [LINE_BYTES*8-1:0]            ic_dat_i,
  input  logic                               adv_i,
  input  logic [4:0]                         len_i,
  input  logic                               bp_taken_i,
  input  logic [AW-1:0]                      bp_tgt_i,
  input  logic                               redirect_i,
  input  logic [AW-1:0]                      redirect_adr_i,
  output logic                               v_o,
  output logic                               predict_taken_o,
  output logic [(LINE_BYTES+MAX_ILEN)*8-1:0] cacheline_o,
  output logic [AW-1:0]                      ip_o,
  output logic [AW-1:0]                      pip_o
);

  localparam int unsigned   OFFW      = $clog2(LINE_BYTES);
  localparam logic [AW-1:0] LINE_STEP = AW'(LINE_BYTES);
  localparam logic [AW-1:0] LINE_MASK = ~(AW'(LINE_BYTES - 1));

  eIfState                 state, state_nx;
  logic [AW-1:0]           ip, pip, pend_adr;
  logic                    pend, drop;

  logic                    l0_v, l1_v, l0_hit, l1_hit;
  logic [AW-1:0]           l0_tag, l1_tag;
  logic [LINE_BYTES*8-1:0] l0_data, l1_data;

  logic [AW-1:0]           line_ip, nip, nip_line, need_adr;
  logic [OFFW:0]           off_end;
  logic                    fits, adv, shift, int_redir, redir_any;
  logic                    ack_any, ack_ok, ack_to0, ack_to1, issue;

  assign line_ip  = ip & LINE_MASK;
  assign nip      = bp_taken_i ? bp_tgt_i : ip + AW'(len_i);
  assign nip_line = nip & LINE_MASK;
  assign off_end  = {1'b0, ip[OFFW-1:0]} + (OFFW+1)'(MAX_ILEN);
  assign fits     = off_end <= (OFFW+1)'(LINE_BYTES);

  assign v_o             = rst_n && l0_v && (fits || l1_v) && !redirect_i;
  assign predict_taken_o = bp_taken_i && v_o;
  assign cacheline_o     = {l1_data[MAX_ILEN*8-1:0], l0_data};
  assign ip_o            = ip;
  assign pip_o           = pip;
  assign ic_req_o        = pend;
  assign ic_adr_o        = pend_adr;

  // L0 always holds line(ip) when valid, so an L0 hit on line(nip) means no line change.
  assign adv       = adv_i && v_o;
  assign shift     = adv && !l0_hit && l1_hit;
  assign int_redir = adv && !l0_hit && !l1_hit;
  assign redir_any = redirect_i || int_redir;

  // Ack routing compares pend_adr against the tags the slots will carry after any shift.
  assign ack_any = ic_ack_i && pend;
  assign ack_ok  = ack_any && !drop && !redir_any;
  assign ack_to0 = ack_ok && !shift && !l0_v && (pend_adr == line_ip);
  assign ack_to1 = ack_ok && !ack_to0 &&
                   (shift ? (pend_adr == l1_tag + LINE_STEP)
                          : (l0_v && (pend_adr == l0_tag + LINE_STEP)));

  assign need_adr = (state == IFS_FILL0) ? line_ip : line_ip + LINE_STEP;
  assign issue    = !pend && !redir_any &&
                    ((state == IFS_FILL0) ||
                     (((state == IFS_FILL1) || (state == IFS_RUN)) && !l1_v));

  always_comb begin
    state_nx = state;
    unique case (state)
      IFS_IDLE:  state_nx = IFS_FILL0;
      IFS_FILL0: if (ack_to0) state_nx = IFS_FILL1;
      IFS_FILL1: if (ack_to1) state_nx = IFS_RUN;
      default:   state_nx = state;
    endcase
    if (redir_any) state_nx = IFS_FILL0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IFS_IDLE;
      ip       <= RST_ADDR;
      pip      <= RST_ADDR;
      pend     <= 1'b0;
      drop     <= 1'b0;
      pend_adr <= '0;
    end else begin
      state <= state_nx;
      if (redirect_i) ip <= redirect_adr_i;
      else if (adv)   ip <= nip;
      if (adv) pip <= ip;
      if (ack_any) begin
        pend <= 1'b0;
        drop <= 1'b0;
      end else if (issue) begin
        pend     <= 1'b1;
        pend_adr <= need_adr;
      end
      if (redir_any && pend && !ic_ack_i) drop <= 1'b1;
    end
  end

  any1_ifetch_lreg #(.LINE_BYTES(LINE_BYTES), .AW(AW)) u_l0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shift || ack_to0),
    .inval     (redir_any),
    .load_tag  (shift ? l1_tag : pend_adr),
    .load_data (shift ? l1_data : ic_dat_i),
    .cmp_tag   (nip_line),
    .v         (l0_v),
    .tag       (l0_tag),
    .data      (l0_data),
    .hit       (l0_hit)
  );

  any1_ifetch_lreg #(.LINE_BYTES(LINE_BYTES), .AW(AW)) u_l1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ack_to1),
    .inval     (redir_any || shift),
    .load_tag  (pend_adr),
    .load_data (ic_dat_i),
    .cmp_tag   (nip_line),
    .v         (l1_v),
    .tag       (l1_tag),
    .data      (l1_data),
    .hit       (l1_hit)
  );

endmodule
